adc_scan_ctrl: RTL

- Scan scheduler for the three serial ADC interface engines (ADC0..ADC2).
- On a programmable period tick, it walks the enabled channel list. For each channel it issues one simultaneous conversion request to all three engines and collects their completion pulses plus 12-bit samples.
- It then serialises the results in fixed order into a single valid/ready stream feeding the SSI transmit path toward the ARM.
- Runs in the 110 MHz clk domain. The engines and the SSI formatter are separate blocks.

---
 rtl/adc_scan_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/adc_scan_ctrl.sv
// Periodic scan scheduler for three ADC engines; serialises samples into one valid/ready stream.
// Optional macro ADC_TIMEOUT_EN adds a WAIT_ACK timeout with a sticky tmo_err flag.
module adc_scan_ctrl #(
  parameter int unsigned NCH = 8,
  parameter int unsigned DW  = 12,
  parameter int unsigned PW  = 16,
  parameter int unsigned TMO = 4096,
  localparam int unsigned CW = $clog2(NCH),
  localparam int unsigned OW = 2 + CW + DW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           scan_en,
  input  logic [PW-1:0]  scan_period,
  input  logic [NCH-1:0] ch_mask,
  output logic [2:0]     conv_req,
  output logic [CW-1:0]  conv_ch,
  input  logic [2:0]     conv_ack,
  input  logic [DW-1:0]  conv_data0,
  input  logic [DW-1:0]  conv_data1,
  input  logic [DW-1:0]  conv_data2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OW-1:0]  out_data,
  output logic           scan_busy,
  output logic [15:0]    scan_cnt,
  output logic           overrun,
  output logic           tmo_err
);

  localparam int unsigned CWP = CW + 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, DRAIN, NEXT} state_t;

  typedef struct packed {
    logic [1:0]    adc_id;
    logic [CW-1:0] ch;
    logic [DW-1:0] sample;
  } word_t;

  state_t        state, state_d;
  logic [PW-1:0] per_cnt, per_cnt_d;
  logic          tick, scan_en_q, en_rise;
  logic [CW-1:0] ch_idx, ch_idx_d;
  logic [2:0]    got, got_d, got_nxt, conv_req_d;
  logic [DW-1:0] smp [3];
  logic [DW-1:0] smp_d [3];
  logic [DW-1:0] din [3];
  logic          out_valid_d, scan_busy_d, overrun_d;
  logic [15:0]   scan_cnt_d;
  word_t         word, word_d;
  logic [CW:0]   first_ch, next_ch;
  logic [1:0]    k_sel;
  logic [DW-1:0] sel_smp;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [CW:0] next_set(input logic [NCH-1:0] mask, input logic [CW:0] from);
    logic [CW:0] r;
    r = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask[i] && (CWP'(i) >= from)) r = {1'b1, CW'(i)};
    end
    return r;
  endfunction

  assign din[0]    = conv_data0;
  assign din[1]    = conv_data1;
  assign din[2]    = conv_data2;
  assign conv_ch   = ch_idx;
  assign out_data  = word;
  assign tick      = scan_en && (per_cnt == scan_period);
  assign en_rise   = scan_en && !scan_en_q;
  assign per_cnt_d = (!scan_en || tick) ? '0 : per_cnt + PW'(1);
  assign first_ch  = next_set(ch_mask, '0);
  assign next_ch   = next_set(ch_mask, CWP'(ch_idx) + CWP'(1));

  // Lowest pending engine for the next drain word.
  always_comb begin
    k_sel   = 2'd2;
    sel_smp = smp[2];
    if (got[0]) begin
      k_sel   = 2'd0;
      sel_smp = smp[0];
    end else if (got[1]) begin
      k_sel   = 2'd1;
      sel_smp = smp[1];
    end
  end

`ifdef ADC_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO);
  logic [TW-1:0] tmo_cnt, tmo_cnt_d;
  logic          tmo_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_d;
      tmo_err <= tmo_err_d;
    end
  end
`else
  // Constant 0 for any legal TMO; no timeout logic exists in this build.
  assign tmo_err = (TMO == 0);
`endif

  always_comb begin
    state_d     = state;
    ch_idx_d    = ch_idx;
    got_d       = got;
    smp_d       = smp;
    out_valid_d = out_valid;
    word_d      = word;
    scan_busy_d = scan_busy;
    scan_cnt_d  = scan_cnt;
    conv_req_d  = '0;
    overrun_d   = overrun;
    got_nxt     = got | conv_ack;
`ifdef ADC_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    tmo_err_d   = tmo_err;
    if (en_rise) tmo_err_d = 1'b0;
`endif
    if (en_rise) overrun_d = 1'b0;

    case (state)
      IDLE: begin
        if (tick && first_ch[CW]) begin
          ch_idx_d    = first_ch[CW-1:0];
          scan_busy_d = 1'b1;
          conv_req_d  = 3'b111;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        got_d   = '0;
        state_d = WAIT_ACK;
`ifdef ADC_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT_ACK: begin
        got_d = got_nxt;
        for (int k = 0; k < 3; k++) begin
          if (conv_ack[k] && !got[k]) smp_d[k] = din[k];
        end
        if (got_nxt == 3'b111) begin
          state_d = DRAIN;
`ifdef ADC_TIMEOUT_EN
        end else if (tmo_cnt == TW'(TMO - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = (got_nxt == 3'b000) ? NEXT : DRAIN;
        end else begin
          tmo_cnt_d = tmo_cnt + TW'(1);
`endif
        end
      end
      DRAIN: begin
        // got doubles as the pending-word mask; a transfer retires the current engine.
        if (out_valid) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            got_d       = got & ~(3'b001 << word.adc_id);
          end
        end else if (got != 3'b000) begin
          out_valid_d   = 1'b1;
          word_d.adc_id = k_sel;
          word_d.ch     = ch_idx;
          word_d.sample = sel_smp;
        end else begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (scan_en && next_ch[CW]) begin
          ch_idx_d   = next_ch[CW-1:0];
          conv_req_d = 3'b111;
          state_d    = ISSUE;
        end else begin
          scan_cnt_d  = scan_cnt + 16'd1;
          scan_busy_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (tick && scan_busy) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      scan_en_q <= 1'b0;
      ch_idx    <= '0;
      got       <= '0;
      smp       <= '{default: '0};
      out_valid <= 1'b0;
      word      <= '0;
      scan_busy <= 1'b0;
      scan_cnt  <= '0;
      conv_req  <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_d;
      per_cnt   <= per_cnt_d;
      scan_en_q <= scan_en;
      ch_idx    <= ch_idx_d;
      got       <= got_d;
      smp       <= smp_d;
      out_valid <= out_valid_d;
      word      <= word_d;
      scan_busy <= scan_busy_d;
      scan_cnt  <= scan_cnt_d;
      conv_req  <= conv_req_d;
      overrun   <= overrun_d;
    end
  end

endmodule
